sfifo_reader: RTL and testbench
===============================

SFIFO_READER -- requirements
Module: sfifo_reader

Interface
REQ-001 Parameter: W, default 8, data width in bits, shared with the FIFO it drains.
REQ-002 Parameter: LW, default 8, width of burst_len and count.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  burst request, sampled only in IDLE.
REQ-006 Port: burst_len  input  LW  words to transfer, sampled with start.
REQ-007 Port: fifo_empty  input  1  FIFO empty flag.
REQ-008 Port: fifo_r  output  1  FIFO read strobe.
REQ-009 Port: fifo_r_data  input  W  FIFO read data, valid the cycle after fifo_r.
REQ-010 Port: m_valid  output  1  output stream valid.
REQ-011 Port: m_ready  input  1  output stream ready.
REQ-012 Port: m_data  output  W  output stream data.
REQ-013 Port: busy  output  1  high while the FSM is not IDLE.
REQ-014 Port: done  output  1  one-cycle burst-complete pulse.
REQ-015 Port: count  output  LW  words handed off on the m side in the current burst.

Function
REQ-016 FSM states are IDLE, RUN and DRAIN; busy = (state != IDLE).
REQ-017 IDLE with start=1 and burst_len!=0: go to RUN, load issue counter with burst_len, clear count.
REQ-018 IDLE with start=1 and burst_len=0: stay in IDLE, pulse done in the next cycle, no fifo_r.
REQ-019 start outside IDLE is ignored.
REQ-020 fifo_r = (state==RUN) & !fifo_empty & (issue counter != 0) & (occ + pend - pop < 2).
REQ-021 In REQ-020, occ is the skid-buffer occupancy (0..2), pend is the read-in-flight flag, and pop = m_valid & m_ready.
REQ-022 fifo_r shall never be high while fifo_empty is high.
REQ-023 pend is registered as fifo_r; while pend=1, fifo_r_data is written into the 2-entry skid buffer at that clock edge.
REQ-024 Each fifo_r decrements the issue counter; RUN goes to DRAIN on the edge where the counter reaches 0.
REQ-025 m_valid = (occ != 0); m_data = buffer head; the buffer is FIFO-ordered with no loss or duplication.
REQ-026 A same-cycle buffer write and pop leaves occ unchanged; data order is preserved.
REQ-027 Latency: with start high in cycle N, fifo_r rises no earlier than N+1 and m_valid no earlier than N+3.
REQ-028 Throughput: one word per cycle sustained while fifo_empty=0 and m_ready=1.
REQ-029 count increments on each pop and saturates at burst_len.
REQ-030 DRAIN goes to IDLE on the edge where occ becomes 0 with pend=0.
REQ-031 done is high for exactly the one cycle after that edge, and count holds its final value until the next accepted start.
REQ-032 When fifo_empty rises mid-burst, the block stalls in RUN with no timeout and resumes when fifo_empty falls.

Reset
REQ-033 rst=1 forces immediately, without a clock: state=IDLE, occ=0, pend=0, issue counter=0.
REQ-034 rst=1 forces immediately: fifo_r=0, m_valid=0, m_data=0, busy=0, done=0, count=0.
REQ-035 Reset mid-burst discards buffered and in-flight words; words already popped from the FIFO are not replayed.

Verification
REQ-036 Reset: assert rst mid-burst between clock edges -> fifo_r, m_valid, busy, done and count read 0 before the next edge.
REQ-037 Full burst: FIFO preloaded with 00..07, burst_len=8, m_ready=1, start in cycle N.
REQ-037a Expected for full burst: fifo_r high N+1..N+8; m_data 00..07 in cycles N+3..N+10; done in N+11; count=8.
REQ-038 Backpressure: m_ready=0 for 5 cycles mid-burst -> occ<=2, fifo_r deasserts, output order 00..07 intact, no duplicates.
REQ-039 Starved FIFO: burst_len=4 with 2 words loaded, 2 more written 10 cycles later.
REQ-039a Expected for starved FIFO: fifo_r never high while fifo_empty=1, busy stays 1, done follows the 4th pop.
REQ-040 Zero length: start with burst_len=0 -> done one cycle later, fifo_r never asserted, busy stays 0.
REQ-041 Start while busy: pulse start with burst_len=3 during an 8-word burst -> ignored, exactly 8 words and one done.

Source files
------------

// File: rtl/sfifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_reader
// Function : Drains a burst of words from a synchronous FIFO into a
//            valid/ready stream through a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module sfifo_reader #(
    parameter int W  = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] burst_len,
    input  logic          fifo_empty,
    output logic          fifo_r,
    input  logic [W-1:0]  fifo_r_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [LW-1:0] r_issue;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_count;
    logic          r_pend;
    logic          r_done;
    logic [1:0]    r_occ;
    logic [W-1:0]  r_buf [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;

    logic          w_pop;
    logic [2:0]    w_load;
    logic [1:0]    w_occ_next;

    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf[r_rd_ptr];
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign count      = r_count;
    assign w_pop      = m_valid & m_ready;

    // Occupancy the buffer will have after this edge; a read issued now
    // lands one cycle later, so it must fit on top of this value.
    assign w_load     = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_occ_next = w_load[1:0];
    assign fifo_r     = (r_state == ST_RUN) && !fifo_empty &&
                        (r_issue != '0) && (w_load < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_issue  <= '0;
            r_len    <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
            r_done   <= 1'b0;
            r_occ    <= 2'd0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pend <= fifo_r;
            r_occ  <= w_occ_next;

            if (r_pend) begin
                r_buf[r_wr_ptr] <= fifo_r_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (r_count != r_len) begin
                    r_count <= r_count + LW'(1);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            r_state <= ST_RUN;
                            r_issue <= burst_len;
                            r_len   <= burst_len;
                            r_count <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (fifo_r) begin
                        r_issue <= r_issue - LW'(1);
                        if (r_issue == LW'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((w_occ_next == 2'd0) && !r_pend) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sfifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfifo_reader
// Function : Directed and randomized bench for sfifo_reader against a
//            burst-level reference model of the expected output stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfifo_reader;

    localparam int W  = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          fifo_empty;
    logic          fifo_r;
    logic [W-1:0]  fifo_r_data = '0;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          busy;
    logic          done;
    logic [LW-1:0] count;

    int total = 0;
    int bad   = 0;

    // FIFO model: words are stored at increasing indices and never overwritten
    logic [W-1:0] mem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;

    // Reference model: the k-th word handed off overall is mem[exp_idx]
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;
    int   exp_cnt  = 0;
    int   exp_rem  = 0;
    int   exp_idx  = 0;

    sfifo_reader #(.W(W), .LW(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .burst_len   (burst_len),
        .fifo_empty  (fifo_empty),
        .fifo_r      (fifo_r),
        .fifo_r_data (fifo_r_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_r && (wr_ptr != rd_ptr)) begin
            fifo_r_data <= mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    // One clock cycle: drive inputs after the falling edge, check, advance model
    task automatic tick(input logic s, input logic [LW-1:0] l, input logic rdy);
        logic pop;
        logic was_busy;
        logic nxt_done;
        @(negedge clk);
        start     = s;
        burst_len = l;
        m_ready   = rdy;
        #1;
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("count", count, exp_cnt);
        if (fifo_r) chk("fifo_r_while_empty", fifo_empty, 0);
        was_busy = exp_busy;
        nxt_done = 1'b0;
        pop      = m_valid & m_ready;
        if (!was_busy) begin
            chk("m_valid_idle", m_valid, 0);
            chk("fifo_r_idle", fifo_r, 0);
        end else if (pop) begin
            chk("m_data", m_data, mem[exp_idx]);
            exp_idx++;
            exp_cnt++;
            exp_rem--;
            if (exp_rem == 0) begin
                exp_busy = 1'b0;
                nxt_done = 1'b1;
            end
        end
        if (!was_busy && s) begin
            if (l == '0) begin
                nxt_done = 1'b1;
            end else begin
                exp_busy = 1'b1;
                exp_rem  = int'(l);
                exp_cnt  = 0;
            end
        end
        exp_done = nxt_done;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (exp_busy && n < 400) begin
            tick(1'b0, '0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (rnd && ($urandom_range(0, 1) == 1) && (wr_ptr - rd_ptr < 12) && (wr_ptr < 1000))
                push(W'($urandom));
            n++;
        end
        if (n >= 400) chk("burst_timeout", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        burst_len = '0;
        m_ready   = 1'b0;
        #2;
        chk("rst_fifo_r", fifo_r, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full burst with fixed latency, words 00..07
        for (int i = 0; i < 8; i++) push(W'(i));
        tick(1'b1, 8'd8, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, '0, 1'b1);
            chk("lat_fifo_r", fifo_r, (k <= 8));
            chk("lat_m_valid", m_valid, (k >= 3 && k <= 10));
            chk("lat_done", done, (k == 11));
        end
        chk("full_count", count, 8);

        // Backpressure mid-burst
        for (int i = 0; i < 8; i++) push(W'(i));
        tick(1'b1, 8'd8, 1'b1);
        repeat (3) tick(1'b0, '0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            tick(1'b0, '0, 1'b0);
            chk("bp_fifo_r", fifo_r, 0);
        end
        wait_idle(1'b0);
        repeat (2) tick(1'b0, '0, 1'b1);

        // Starved FIFO
        push(W'($urandom));
        push(W'($urandom));
        tick(1'b1, 8'd4, 1'b1);
        repeat (10) tick(1'b0, '0, 1'b1);
        chk("starve_busy", busy, 1);
        push(W'($urandom));
        push(W'($urandom));
        wait_idle(1'b0);
        repeat (2) tick(1'b0, '0, 1'b1);

        // Zero-length request with data available
        push(W'($urandom));
        tick(1'b1, 8'd0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            tick(1'b0, '0, 1'b1);
            chk("zero_fifo_r", fifo_r, 0);
            chk("zero_busy", busy, 0);
        end

        // Start while busy is ignored
        for (int i = 0; i < 7; i++) push(W'($urandom));
        tick(1'b1, 8'd8, 1'b1);
        repeat (3) tick(1'b0, '0, 1'b1);
        tick(1'b1, 8'd3, 1'b1);
        wait_idle(1'b0);
        repeat (3) tick(1'b0, '0, 1'b1);

        // Randomized bursts
        for (int b = 0; b < 8; b++) begin
            tick(1'b1, LW'($urandom_range(1, 12)), 1'b1);
            wait_idle(1'b1);
            repeat ($urandom_range(1, 3)) tick(1'b0, '0, 1'b1);
        end

        // Asynchronous reset mid-burst
        for (int i = 0; i < 6; i++) push(W'($urandom));
        tick(1'b1, 8'd8, 1'b1);
        repeat (4) tick(1'b0, '0, 1'b1);
        @(negedge clk);
        #2;
        start = 1'b0;
        rst   = 1'b1;
        #1;
        chk("arst_fifo_r", fifo_r, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_count", count, 0);
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_cnt  = 0;
        exp_rem  = 0;
        @(negedge clk);
        rst = 1'b0;
        exp_idx = rd_ptr;
        for (int i = 0; i < 4; i++) push(W'($urandom));
        tick(1'b1, 8'd4, 1'b1);
        wait_idle(1'b1);
        repeat (3) tick(1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
